mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port RAM between the datapath's instruction fetch path and its data load/store path. It latches one request per transaction, drives the RAM until it signals ready, and returns a hit to the winning side. Data requests win by default; a starvation counter guarantees fetch progress. A per-access watchdog flags a RAM that never responds. It sits between `datapath` and the RAM model in the top-level system.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the instruction fetch and data load/store paths.
// Data wins by default, a starvation counter forces fetch progress, and a watchdog aborts dead accesses.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              wr_q;
  logic [SC_W-1:0]   starve_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              dreq, grant_d, grant_i, in_acc, timeout;

  assign dreq    = dREN | dWEN;
  assign in_acc  = (state != IDLE);
  // ramready in the expiry cycle takes precedence over the watchdog
  assign timeout = in_acc && !ramready && (wd_cnt == WD_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || (starve_cnt < SC_MAX))) begin
          grant_d    = 1'b1;
          next_state = DACC;
        end else if (iREN) begin
          grant_i    = 1'b1;
          next_state = IACC;
        end
      end
      IACC, DACC: begin
        if (ramready || timeout) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      err        <= 1'b0;
    end else begin
      if (grant_d || grant_i) begin
        addr_q <= grant_d ? daddr : iaddr;
        wd_cnt <= '0;
      end else if (in_acc && !ramready) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (grant_d) begin
        wr_q   <= dWEN;
        data_q <= dstore;
        if (iREN && (starve_cnt != SC_MAX)) starve_cnt <= starve_cnt + SC_W'(1);
      end
      if (grant_i) starve_cnt <= '0;
      if (timeout) err <= 1'b1;
    end
  end

  // RAM side is driven only from latched registers; hits need the owner still requesting
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    case (state)
      IACC: begin
        ramREN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = data_q;
        if (ramready && iREN) begin
          ihit  = 1'b1;
          iload = ramload;
        end
      end
      DACC: begin
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = data_q;
        if (ramready && dreq) begin
          dhit  = 1'b1;
          dload = wr_q ? '0 : ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a scoreboard of expected hits is filled as requests are
// driven and drained by a monitor that watches ihit/dhit on every falling edge.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [31:0] ramData;
  logic        useModel;

  typedef struct {
    bit          isData;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  // Directed tests drive ramData; the starvation run uses an address-derived RAM model
  assign ramload = useModel ? ~ramaddr : ramData;

  mem_arbiter #(
    .WORD_W(32), .ADDR_W(32), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Every hit must match the oldest scoreboard entry; loads must be zero when not hitting
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit || dhit) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected hit", 64'(1), 64'(0));
        end else begin
          monE = sb.pop_front();
          checkOutput("hit side", 64'({ihit, dhit}), monE.isData ? 64'(1) : 64'(2));
          checkOutput("hit data", 64'(ihit ? iload : dload), 64'(monE.data));
        end
      end else begin
        checkOutput("load gated", 64'({iload, dload}), 64'(0));
      end
    end
  end

  // kind: 0 fetch, 1 data read, 2 data write; RAM answers on the lat-th access cycle
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int lat);
    int   waits;
    logic granted;
    exp_t e;
    case (kind)
      0:       begin iREN = 1'b1; iaddr = addr; end
      1:       begin dREN = 1'b1; daddr = addr; end
      default: begin dWEN = 1'b1; daddr = addr; dstore = wdata; end
    endcase
    e.isData = (kind != 0);
    e.data   = (kind == 2) ? 32'h0 : rdata;
    sb.push_back(e);
    waits   = 0;
    granted = 1'b0;
    while (!granted && waits < 8) begin
      tick();
      waits++;
      granted = ramREN | ramWEN;
    end
    checkOutput("grant latency", 64'(waits), 64'(1));
    if (granted) begin
      iaddr  = ~addr;
      daddr  = ~addr;
      dstore = ~wdata;
      for (int c = 1; c <= lat; c++) begin
        ramready = (c == lat);
        ramData  = (c == lat) ? rdata : 32'h0;
        @(negedge CLK);
        if (c == lat) begin
          checkOutput("ramaddr", 64'(ramaddr), 64'(addr));
          checkOutput("ramREN", 64'(ramREN), 64'(kind != 2));
          checkOutput("ramWEN", 64'(ramWEN), 64'(kind == 2));
          if (kind == 2) checkOutput("ramstore", 64'(ramstore), 64'(wdata));
        end else begin
          checkOutput("early hit", 64'(ihit | dhit), 64'(0));
        end
        tick();
      end
    end
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramready = 1'b0;
    ramData  = 32'h0;
    checkOutput("queue drained", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    exp_t e;
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h100; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramready = 1'b1; ramData = 32'h11112222; useModel = 1'b0;

    // Reset holds everything quiet even with a request and a ready RAM
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset ihit", 64'(ihit), 64'(0));
    checkOutput("reset ramREN", 64'(ramREN), 64'(0));
    checkOutput("reset err", 64'(err), 64'(0));
    checkOutput("reset ramaddr", 64'(ramaddr), 64'(0));
    e.isData = 1'b0; e.data = 32'h11112222;
    sb.push_back(e);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("idle after release", 64'(ramREN), 64'(0));
    tick();
    @(negedge CLK);
    checkOutput("first fetch ramREN", 64'(ramREN), 64'(1));
    checkOutput("first fetch ramaddr", 64'(ramaddr), 64'(32'h100));
    tick();
    iREN = 1'b0; ramready = 1'b0; ramData = 32'h0;
    checkOutput("reset fetch drained", 64'(sb.size()), 64'(0));
    tick();

    // Single fetch, store, data read
    applyStimulus(0, 32'h40, 32'h0, 32'h2108000A, 3);
    applyStimulus(2, 32'h80, 32'hDEADBEEF, 32'h12345678, 1);
    applyStimulus(1, 32'hC0, 32'h0, 32'hCAFEF00D, 2);

    // Ready arrives in the very cycle the watchdog would expire
    applyStimulus(1, 32'h900, 32'h0, 32'h5555AAAA, 64);
    checkOutput("err after ready at expiry", 64'(err), 64'(0));

    // Both requests held: four data grants then one fetch, twice
    useModel = 1'b1;
    for (int g = 0; g < 10; g++) begin
      e.isData = ((g % 5) != 4);
      e.data   = e.isData ? ~32'h800 : ~32'h400;
      sb.push_back(e);
    end
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h800; ramready = 1'b1;
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    tick();
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0; useModel = 1'b0;
    checkOutput("starvation queue drained", 64'(sb.size()), 64'(0));
    sb.delete();
    tick();

    // Dead RAM: the watchdog drops the access after 64 cycles
    dREN = 1'b1; daddr = 32'hA00; ramready = 1'b0; ramData = 32'h0;
    tick();
    checkOutput("timeout grant", 64'(ramREN), 64'(1));
    repeat (63) tick();
    @(negedge CLK);
    checkOutput("err before expiry", 64'(err), 64'(0));
    checkOutput("still in access", 64'(ramREN), 64'(1));
    tick();
    dREN = 1'b0;
    @(negedge CLK);
    checkOutput("err after expiry", 64'(err), 64'(1));
    checkOutput("idle after expiry", 64'(ramREN), 64'(0));
    tick();
    applyStimulus(1, 32'hA04, 32'h0, 32'h0F0F0F0F, 1);
    checkOutput("err sticky", 64'(err), 64'(1));

    // Fetch withdrawn mid-access: RAM completes, no hit
    iREN = 1'b1; iaddr = 32'h600;
    tick();
    checkOutput("abort grant", 64'(ramREN), 64'(1));
    iREN = 1'b0;
    tick();
    tick();
    ramready = 1'b1; ramData = 32'hBAD0BAD0;
    @(negedge CLK);
    checkOutput("abort no ihit", 64'(ihit), 64'(0));
    checkOutput("abort still reading", 64'(ramREN), 64'(1));
    tick();
    ramready = 1'b0; ramData = 32'h0;
    checkOutput("abort back to idle", 64'(ramREN), 64'(0));
    applyStimulus(0, 32'h604, 32'h0, 32'h7E7E7E7E, 2);

    // Reset in the middle of an access drops strobes immediately and clears err
    iREN = 1'b1; iaddr = 32'h700;
    tick();
    checkOutput("pre-reset access", 64'(ramREN), 64'(1));
    #2;
    nRST = 1'b0;
    ramready = 1'b1;
    #1;
    checkOutput("async reset ramREN", 64'(ramREN), 64'(0));
    checkOutput("async reset ihit", 64'(ihit), 64'(0));
    checkOutput("async reset err", 64'(err), 64'(0));
    iREN = 1'b0; ramready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
